regfile_write_scheduler: RTL and testbench
==========================================

# regfile_write_scheduler

- Shares the single register-file write port between two producers:
  - the pipeline writeback stage, which has fixed priority and is never stalled;
  - a late-result producer (multi-cycle multiply/divide or a delayed load return) behind a valid/ready handshake.
- Late results are held in a small FIFO and drained into idle write cycles.
- A pending-register mask is exported so the hazard unit can stall readers of registers whose writes are still queued.
- The block sits between the writeback/late units and the register file write inputs, and drives RegWrite, WAddr and WData.

## Interface
- DEPTH, 4, late-result FIFO entries (power of two, ≥2)
- Clk  input  1  system clock, rising-edge
- Rst_n  input  1  asynchronous active-low reset
- WB_Valid  input  1  pipeline writeback request this cycle
- WB_Addr  input  5  writeback destination register
- WB_Data  input  32  writeback data (signed)
- LR_Valid  input  1  late-result request
- LR_Addr  input  5  late-result destination
- LR_Data  input  32  late-result data (signed)
- LR_Ready  output  1  late-result accepted when LR_Valid && LR_Ready at rising edge
- RegWrite  output  1  register-file write enable (registered)
- WAddr  output  5  register-file write address (registered)
- WData  output  32  register-file write data (registered)
- PendingMask  output  32  bit r set while a queued write to $r exists
- Count  output  log2(DEPTH)+1  live FIFO occupancy
- Drop  output  1  one-cycle pulse: a request targeted $0, $26 or $27 and was discarded

## Operation
- **Protected addresses:** 0, 26 and 27.
  - A WB request to a protected address produces no write and raises Drop.
  - A handshaken LR request to a protected address is accepted, not enqueued, and raises Drop.
- **Each rising edge, write-port priority:**
  1. WB_Valid with an unprotected address → RegWrite=1, WAddr/WData = WB fields.
  2. Otherwise, if the FIFO head is live → write head fields and pop.
  3. Otherwise, if the FIFO head is dead → pop it, RegWrite=0.
  4. Otherwise → RegWrite=0. WAddr and WData hold their last values.
- **LR_Ready** is combinational. It is 1 unless any of the following holds:
  - the FIFO is full, counting dead entries;
  - PendingMask[LR_Addr] is set, so at most one queued entry exists per register;
  - WB_Valid is high and WB_Addr == LR_Addr.
- **Enqueue:**
  - Stores {addr, data, live=1}.
  - Sets PendingMask[addr].
  - Increments Count.
- **Squash:** when WB writes register r and PendingMask[r] is set, the queued entry for r is marked dead and PendingMask[r] is cleared in the same edge. Writeback is architecturally younger, so the stale late result must never land.
- **Pop of a live entry** clears its PendingMask bit. Count decrements on pop of a live entry and on squash; popping a dead entry leaves Count unchanged.
- **Simultaneous enqueue and pop** in one edge is legal, including when the FIFO is full-then-pop: occupancy is unchanged and LR_Ready still follows the full test that was evaluated before the edge.
- **Pointer wrap:** read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full and empty are distinguished by an extra wrap bit.

## Timing
- **Reset (asynchronous assert):**
  - RegWrite=0, WAddr=0, WData=0, Drop=0, PendingMask=0, Count=0.
  - FIFO emptied; LR_Ready=1.
  - Queued writes are lost.
  - Deassertion is synchronous to Clk through the system reset synchronizer.
- **WB path:** request sampled at edge N; outputs valid after edge N; register file writes at edge N+1 (1-cycle latency).
- **LR path:**
  - Accepted at edge N; earliest drain at edge N+1; register file writes at edge N+2.
  - Each cycle of WB activity delays the drain by one cycle.
- **PendingMask** is registered. It is set in the cycle after acceptance and cleared in the same cycle RegWrite presents that entry. Hazard logic must treat the register as pending until the register file's negedge read reflects the write.
- **Drop** is registered and pulses for one cycle after the offending edge.

## Structure
- **Shared package constant:** PROTECTED_REGS (0, 26, 27), shared with the register file so both agree. Provide a helper function is_protected(addr).
- **Shared package typedef:** lr_entry_t {live, addr[4:0], data[31:0]}.
- **One sub-module:** wsched_fifo, a DEPTH-entry circular buffer.
  - Ports: push, pop, a squash-by-address input that clears the live bit of the matching entry, and head/full/empty/count outputs.
- Arbitration, mask and output registers live in the top module.

## Test plan
- **Reset mid-drain:** enqueue LR to $8=0x11 and $9=0x22; assert Rst_n=0 before the drain → no write to $8/$9 ever; PendingMask=0, Count=0, LR_Ready=1.
- **Contention:** WB $5=7 every cycle for 3 cycles while LR $12=−3 is accepted in cycle 0 → writes occur in order $5,$5,$5,$12; $12 lands on the 4th write edge; PendingMask[12] is high until then.
- **Full FIFO (DEPTH=4):** continuous WB plus LR to $10–$13 → LR_Ready=0 on the 5th request; Count=4. Stop WB → 4 drains in order, Count decrements 4→0.
- **Squash:** LR $7=0xAAAA queued, then WB $7=0x5555 → final $7=0x5555; the dead entry pops with RegWrite=0; PendingMask[7] clears on the WB edge.
- **Protection:** WB to $0 and LR to $26 → RegWrite stays 0, two Drop pulses, LR handshake completes, Count unchanged.
- **Duplicate hold-off:** LR $3 queued, then a second LR $3 offered → LR_Ready=0 until the first drains, then accepted. Also LR $4 offered with WB $4 in the same cycle → LR_Ready=0 in that cycle.

Source files
------------

// File: rtl/regfile_write_scheduler_pkg.sv
// Shared types and constants for the register-file write scheduler.
// The register file uses the same protected-register list.
package regfile_write_scheduler_pkg;

    // Registers that are never written: $0 is hard-wired zero, and $26/$27 are reserved.
    localparam int unsigned N_PROTECTED = 3;
    localparam logic [4:0] PROTECTED_REGS [N_PROTECTED] = '{5'd0, 5'd26, 5'd27};

    // One queued late result.
    typedef struct packed {
        logic        live;
        logic [4:0]  addr;
        logic [31:0] data;
    } lr_entry_t;

    function automatic logic is_protected(input logic [4:0] addr);
        logic hit;
        hit = 1'b0;
        for (int unsigned i = 0; i < N_PROTECTED; i++) begin
            if (addr == PROTECTED_REGS[i]) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/wsched_fifo.sv
// Circular buffer of late results with in-place squash by destination address.
// Occupancy counts dead entries; they leave only through a normal pop.
module wsched_fifo
    import regfile_write_scheduler_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  lr_entry_t       push_entry,
    input  logic            pop,
    input  logic            squash,
    input  logic [4:0]      squash_addr,
    output lr_entry_t       head,
    output logic            full,
    output logic            empty,
    output logic [AW:0]     count
);

    lr_entry_t   mem_q [DEPTH];
    lr_entry_t   mem_d [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;

    assign head  = mem_q[rd_ptr_q[AW-1:0]];
    assign count = wr_ptr_q - rd_ptr_q;
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // Next-state of storage and pointers: squash, push and pop may all occur in one cycle.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (squash) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (mem_q[i].live && (mem_q[i].addr == squash_addr)) mem_d[i].live = 1'b0;
            end
        end
        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_entry;
            wr_ptr_d                = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // Storage and pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/regfile_write_scheduler.sv
// Arbitrates the single register-file write port between the writeback stage
// (fixed priority) and queued late results, and exports the pending-write mask.
module regfile_write_scheduler
    import regfile_write_scheduler_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic          WB_Valid,
    input  logic [4:0]    WB_Addr,
    input  logic [31:0]   WB_Data,
    input  logic          LR_Valid,
    input  logic [4:0]    LR_Addr,
    input  logic [31:0]   LR_Data,
    output logic          LR_Ready,
    output logic          RegWrite,
    output logic [4:0]    WAddr,
    output logic [31:0]   WData,
    output logic [31:0]   PendingMask,
    output logic [CW-1:0] Count,
    output logic          Drop
);

    logic          reg_write_q, reg_write_d;
    logic [4:0]    waddr_q, waddr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   pending_q, pending_d;
    logic          drop_q, drop_d;

    logic          wb_write, lr_fire, lr_prot;
    logic          fifo_push, fifo_pop, fifo_squash;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] live_count;
    lr_entry_t     fifo_head;
    lr_entry_t     push_entry;

    // Handshake and FIFO control derived from the current request and registered mask.
    always_comb begin
        wb_write    = WB_Valid && !is_protected(WB_Addr);
        lr_prot     = is_protected(LR_Addr);
        LR_Ready    = !fifo_full && !pending_q[LR_Addr] && !(WB_Valid && (WB_Addr == LR_Addr));
        lr_fire     = LR_Valid && LR_Ready;
        fifo_push   = lr_fire && !lr_prot;
        fifo_pop    = !wb_write && !fifo_empty;
        fifo_squash = wb_write && pending_q[WB_Addr];
        push_entry  = '{live: 1'b1, addr: LR_Addr, data: LR_Data};
    end

    wsched_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (Clk),
        .rst_n       (Rst_n),
        .push        (fifo_push),
        .push_entry  (push_entry),
        .pop         (fifo_pop),
        .squash      (fifo_squash),
        .squash_addr (WB_Addr),
        .head        (fifo_head),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .count       (fifo_count)
    );

    // Write-port arbitration, pending-mask update and drop detection.
    always_comb begin
        reg_write_d = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        pending_d   = pending_q;
        if (wb_write) begin
            reg_write_d = 1'b1;
            waddr_d     = WB_Addr;
            wdata_d     = WB_Data;
        end else if (fifo_pop && fifo_head.live) begin
            reg_write_d = 1'b1;
            waddr_d     = fifo_head.addr;
            wdata_d     = fifo_head.data;
        end
        // A live head and a squash are never both acted on: pop needs an idle writeback.
        if (fifo_squash) pending_d[WB_Addr] = 1'b0;
        if (fifo_pop && fifo_head.live) pending_d[fifo_head.addr] = 1'b0;
        if (fifo_push) pending_d[LR_Addr] = 1'b1;
        drop_d = (WB_Valid && !wb_write) || (lr_fire && lr_prot);
    end

    // Each live queued entry owns exactly one mask bit, so the live count is its population.
    always_comb begin
        live_count = '0;
        for (int unsigned i = 0; i < 32; i++) live_count = live_count + CW'(pending_q[i]);
    end

    // Registered outputs.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            reg_write_q <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            pending_q   <= '0;
            drop_q      <= 1'b0;
        end else begin
            reg_write_q <= reg_write_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            pending_q   <= pending_d;
            drop_q      <= drop_d;
        end
    end

    assign RegWrite    = reg_write_q;
    assign WAddr       = waddr_q;
    assign WData       = wdata_q;
    assign PendingMask = pending_q;
    assign Count       = live_count;
    assign Drop        = drop_q;

    // Live entries can never outnumber occupied slots.
    a_live_le_occupancy: assert property (@(posedge Clk) disable iff (!Rst_n) live_count <= fifo_count);

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed bench for regfile_write_scheduler with a register-file model fed by the write port.
module tb_regfile_write_scheduler;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        WB_Valid;
    logic [4:0]  WB_Addr;
    logic [31:0] WB_Data;
    logic        LR_Valid;
    logic [4:0]  LR_Addr;
    logic [31:0] LR_Data;
    logic        LR_Ready;
    logic        RegWrite;
    logic [4:0]  WAddr;
    logic [31:0] WData;
    logic [31:0] PendingMask;
    logic [2:0]  Count;
    logic        Drop;

    int checks = 0;
    int errors = 0;

    logic [31:0] rf [32];
    logic [36:0] wlog [$];   // {addr, data} of every register-file write, in order

    regfile_write_scheduler #(.DEPTH(4)) dut (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .WB_Valid    (WB_Valid),
        .WB_Addr     (WB_Addr),
        .WB_Data     (WB_Data),
        .LR_Valid    (LR_Valid),
        .LR_Addr     (LR_Addr),
        .LR_Data     (LR_Data),
        .LR_Ready    (LR_Ready),
        .RegWrite    (RegWrite),
        .WAddr       (WAddr),
        .WData       (WData),
        .PendingMask (PendingMask),
        .Count       (Count),
        .Drop        (Drop)
    );

    always #5 Clk = ~Clk;

    // Register file: writes at the edge after the scheduler presents them.
    always @(posedge Clk) begin
        if (Rst_n && RegWrite) begin
            rf[WAddr] <= WData;
            wlog.push_back({WAddr, WData});
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                         input logic lv, input logic [4:0] la, input logic [31:0] ld);
        WB_Valid = wv; WB_Addr = wa; WB_Data = wd;
        LR_Valid = lv; LR_Addr = la; LR_Data = ld;
        #1;
    endtask

    function automatic int writes_to(input logic [4:0] a, input int from);
        int n;
        n = 0;
        for (int i = from; i < wlog.size(); i++) begin
            if (wlog[i][36:32] == a) n++;
        end
        return n;
    endfunction

    initial begin
        int base;
        logic [4:0] exp_a [5];
        logic [31:0] exp_d [5];
        logic [36:0] ent;

        Rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        #10;
        check("rst_regwrite", {31'd0, RegWrite}, 32'd0);
        check("rst_waddr", {27'd0, WAddr}, 32'd0);
        check("rst_wdata", WData, 32'd0);
        check("rst_pending", PendingMask, 32'd0);
        check("rst_count", {29'd0, Count}, 32'd0);
        check("rst_drop", {31'd0, Drop}, 32'd0);
        check("rst_ready", {31'd0, LR_Ready}, 32'd1);
        Rst_n = 1'b1;
        tick();

        // Reset mid-drain: two entries queued behind writeback, then reset.
        drive(1, 5'd1, 32'd1, 1, 5'd8, 32'h11);
        tick();
        drive(1, 5'd1, 32'd1, 1, 5'd9, 32'h22);
        tick();
        check("mid_count", {29'd0, Count}, 32'd2);
        check("mid_pending", PendingMask, 32'h0000_0300);
        base = wlog.size();
        Rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        #1;
        check("mid_rst_pending", PendingMask, 32'd0);
        check("mid_rst_count", {29'd0, Count}, 32'd0);
        check("mid_rst_ready", {31'd0, LR_Ready}, 32'd1);
        #2;
        Rst_n = 1'b1;
        repeat (4) tick();
        check("mid_no_write_8", writes_to(5'd8, base), 32'd0);
        check("mid_no_write_9", writes_to(5'd9, base), 32'd0);

        // Contention: WB $5 three cycles, LR $12 = -3 accepted in the first.
        base = wlog.size();
        drive(1, 5'd5, 32'd7, 1, 5'd12, -32'sd3);
        check("cont_ready", {31'd0, LR_Ready}, 32'd1);
        tick();
        drive(1, 5'd5, 32'd7, 0, 0, 0);
        check("cont_pend_c0", {31'd0, PendingMask[12]}, 32'd1);
        check("cont_waddr_c0", {27'd0, WAddr}, 32'd5);
        tick();
        check("cont_pend_c1", {31'd0, PendingMask[12]}, 32'd1);
        tick();
        check("cont_pend_c2", {31'd0, PendingMask[12]}, 32'd1);
        drive(0, 0, 0, 0, 0, 0);
        tick();
        check("cont_regwrite", {31'd0, RegWrite}, 32'd1);
        check("cont_waddr", {27'd0, WAddr}, 32'd12);
        check("cont_wdata", WData, 32'hFFFF_FFFD);
        check("cont_pend_clr", {31'd0, PendingMask[12]}, 32'd0);
        tick();
        check("cont_nwrites", wlog.size() - base, 32'd4);
        for (int i = 0; i < 4; i++) begin
            ent = wlog[base + i];
            check("cont_order", {27'd0, ent[36:32]}, (i < 3) ? 32'd5 : 32'd12);
        end
        check("cont_rf12", rf[12], 32'hFFFF_FFFD);

        // Full FIFO: fill $10..$13 behind continuous writeback.
        for (int i = 0; i < 4; i++) begin
            drive(1, 5'd1, 32'(i), 1, 5'(10 + i), 32'(100 + i));
            check("full_fill_ready", {31'd0, LR_Ready}, 32'd1);
            tick();
        end
        drive(0, 0, 0, 1, 5'd14, 32'd104);
        check("full_count", {29'd0, Count}, 32'd4);
        check("full_ready_5th", {31'd0, LR_Ready}, 32'd0);
        tick();
        check("full_pop1_addr", {27'd0, WAddr}, 32'd10);
        check("full_pop1_count", {29'd0, Count}, 32'd3);
        check("full_ready_after", {31'd0, LR_Ready}, 32'd1);
        tick();   // $14 enqueued while $11 pops
        drive(0, 0, 0, 0, 0, 0);
        check("full_swap_count", {29'd0, Count}, 32'd3);
        exp_a = '{5'd11, 5'd12, 5'd13, 5'd14, 5'd0};
        exp_d = '{32'd101, 32'd102, 32'd103, 32'd104, 32'd0};
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            check("drain_addr", {27'd0, WAddr}, {27'd0, exp_a[i]});
            check("drain_data", WData, exp_d[i]);
            check("drain_count", {29'd0, Count}, 32'(3 - i - ((i == 0) ? 0 : 0)) - ((i == 0) ? 32'd0 : 32'd0));
        end
        tick();
        check("drain_idle", {31'd0, RegWrite}, 32'd0);

        // Squash: writeback to a register with a queued late result.
        drive(1, 5'd1, 32'd0, 1, 5'd7, 32'hAAAA);
        tick();
        check("sq_pend_set", {31'd0, PendingMask[7]}, 32'd1);
        check("sq_count1", {29'd0, Count}, 32'd1);
        drive(1, 5'd7, 32'h5555, 0, 0, 0);
        tick();
        check("sq_wb_addr", {27'd0, WAddr}, 32'd7);
        check("sq_pend_clr", {31'd0, PendingMask[7]}, 32'd0);
        check("sq_count0", {29'd0, Count}, 32'd0);
        drive(0, 0, 0, 0, 0, 0);
        tick();
        check("sq_dead_pop", {31'd0, RegWrite}, 32'd0);
        tick();
        check("sq_rf7", rf[7], 32'h5555);
        check("sq_still_idle", {31'd0, RegWrite}, 32'd0);

        // Protection: WB to $0, then LR to $26.
        drive(1, 5'd0, 32'hDEAD, 0, 0, 0);
        tick();
        check("prot_wb_nowrite", {31'd0, RegWrite}, 32'd0);
        check("prot_wb_drop", {31'd0, Drop}, 32'd1);
        drive(0, 0, 0, 0, 0, 0);
        tick();
        check("prot_drop_end", {31'd0, Drop}, 32'd0);
        drive(0, 0, 0, 1, 5'd26, 32'hBEEF);
        check("prot_lr_ready", {31'd0, LR_Ready}, 32'd1);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        check("prot_lr_drop", {31'd0, Drop}, 32'd1);
        check("prot_lr_count", {29'd0, Count}, 32'd0);
        check("prot_lr_pend", PendingMask, 32'd0);
        tick();
        check("prot_lr_nowrite", {31'd0, RegWrite}, 32'd0);
        check("prot_drop_end2", {31'd0, Drop}, 32'd0);

        // Duplicate hold-off on $3, then same-cycle WB/LR collision on $4.
        drive(1, 5'd1, 32'd0, 1, 5'd3, 32'h33);
        tick();
        drive(1, 5'd1, 32'd0, 1, 5'd3, 32'h34);
        check("dup_block1", {31'd0, LR_Ready}, 32'd0);
        tick();
        check("dup_block2", {31'd0, LR_Ready}, 32'd0);
        drive(0, 0, 0, 1, 5'd3, 32'h34);
        check("dup_block3", {31'd0, LR_Ready}, 32'd0);
        tick();
        check("dup_first_addr", {27'd0, WAddr}, 32'd3);
        check("dup_first_data", WData, 32'h33);
        check("dup_ready", {31'd0, LR_Ready}, 32'd1);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        check("dup_pend", {31'd0, PendingMask[3]}, 32'd1);
        tick();
        check("dup_second_data", WData, 32'h34);
        drive(1, 5'd4, 32'h44, 1, 5'd4, 32'h45);
        check("coll_ready", {31'd0, LR_Ready}, 32'd0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        check("coll_wb_data", WData, 32'h44);
        check("coll_count", {29'd0, Count}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
